// File: rtl/axi_lite_mem_responder_if.sv
// AXI-Lite style bundle for the 64-bit memory responder: AW, W, B, AR and R channels.
// Signal names carry the responder-side direction suffix so both ends match one naming.
interface axi_lite_mem_responder_if;
  logic [31:0] aw_addr_i;
  logic        aw_valid_i;
  logic        aw_ready_o;
  logic [63:0] w_data_i;
  logic [7:0]  w_strb_i;
  logic        w_valid_i;
  logic        w_ready_o;
  logic [1:0]  b_resp_o;
  logic        b_valid_o;
  logic        b_ready_i;
  logic [31:0] ar_addr_i;
  logic        ar_valid_i;
  logic        ar_ready_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_valid_o;
  logic        r_ready_i;

  modport slave (
    input  aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
    input  ar_addr_i, ar_valid_i, r_ready_i,
    output aw_ready_o, w_ready_o, b_resp_o, b_valid_o,
    output ar_ready_o, r_data_o, r_resp_o, r_valid_o
  );

  modport master (
    output aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
    output ar_addr_i, ar_valid_i, r_ready_i,
    input  aw_ready_o, w_ready_o, b_resp_o, b_valid_o,
    input  ar_ready_o, r_data_o, r_resp_o, r_valid_o
  );
endinterface

// File: rtl/axi_lite_mem_responder.sv
// AXI-Lite style 64-bit memory responder: byte-strobed writes with single B response,
// fixed-latency pipelined reads with an in-order response buffer for R back-pressure.
module axi_lite_mem_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_OUTST    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  axi_lite_mem_responder_if.slave bus
);

  localparam int unsigned IdxW   = $clog2(DEPTH_WORDS);
  localparam int unsigned PtrW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CntW   = $clog2(MAX_OUTST + 1);
  localparam int unsigned Stages = READ_LATENCY - 1;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } rsp_t;

  logic [63:0] mem_q [DEPTH_WORDS];

  // Address decode
  logic [31:0]     aw_off, ar_off;
  logic            aw_hit, ar_hit;
  logic [IdxW-1:0] aw_idx, ar_idx;

  assign aw_off = bus.aw_addr_i - BASE_ADDR;
  assign ar_off = bus.ar_addr_i - BASE_ADDR;
  assign aw_hit = (bus.aw_addr_i >= BASE_ADDR) && ({3'b000, aw_off[31:3]} < DEPTH_WORDS);
  assign ar_hit = (bus.ar_addr_i >= BASE_ADDR) && ({3'b000, ar_off[31:3]} < DEPTH_WORDS);
  assign aw_idx = aw_off[3 +: IdxW];
  assign ar_idx = ar_off[3 +: IdxW];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_off[2:0], ar_off[2:0]};

  // Write channel
  logic       wr_hs;
  logic       b_valid_q;
  logic [1:0] b_resp_q;

  assign wr_hs          = bus.aw_valid_i & bus.w_valid_i & ~b_valid_q;
  assign bus.aw_ready_o = wr_hs;
  assign bus.w_ready_o  = wr_hs;
  assign bus.b_valid_o  = b_valid_q;
  assign bus.b_resp_o   = b_resp_q;

  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_hs && aw_hit) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.w_strb_i[b]) begin
          mem_q[aw_idx][8*b +: 8] <= bus.w_data_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      b_valid_q <= 1'b0;
      b_resp_q  <= RespOkay;
    end else if (wr_hs) begin
      b_valid_q <= 1'b1;
      b_resp_q  <= aw_hit ? RespOkay : RespSlvErr;
    end else if (bus.b_ready_i) begin
      b_valid_q <= 1'b0;
    end
  end

  // Read request side: sample memory in the AR handshake cycle
  logic [CntW-1:0] outst_q;
  logic            ar_hs;
  rsp_t            ar_rsp;

  assign bus.ar_ready_o = (outst_q < CntW'(MAX_OUTST));
  assign ar_hs          = bus.ar_valid_i & bus.ar_ready_o;

  always_comb begin
    ar_rsp.data = '0;
    ar_rsp.resp = RespSlvErr;
    if (ar_hit) begin
      ar_rsp.data = mem_q[ar_idx];
      ar_rsp.resp = RespOkay;
    end
  end

  // Latency pipeline; the response buffer adds the final cycle
  logic push_valid;
  rsp_t push_rsp;

  if (Stages > 0) begin : g_pipe
    logic [Stages-1:0] vld_q;
    rsp_t              rsp_q [Stages];

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= ar_hs;
        rsp_q[0] <= ar_rsp;
        for (int i = 1; i < Stages; i++) begin
          vld_q[i] <= vld_q[i-1];
          rsp_q[i] <= rsp_q[i-1];
        end
      end
    end

    assign push_valid = vld_q[Stages-1];
    assign push_rsp   = rsp_q[Stages-1];
  end else begin : g_nopipe
    assign push_valid = ar_hs;
    assign push_rsp   = ar_rsp;
  end

  // In-order response buffer; outst_q bounds its fill so it can never overflow
  rsp_t            fifo_q [MAX_OUTST];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] fifo_cnt_q;
  logic            r_valid, r_hs;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTST - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign r_valid       = (fifo_cnt_q != '0);
  assign r_hs          = r_valid & bus.r_ready_i;
  assign bus.r_valid_o = r_valid;
  assign bus.r_data_o  = r_valid ? fifo_q[rd_ptr_q].data : '0;
  assign bus.r_resp_o  = r_valid ? fifo_q[rd_ptr_q].resp : RespOkay;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      outst_q    <= '0;
    end else begin
      if (push_valid) begin
        fifo_q[wr_ptr_q] <= push_rsp;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (r_hs) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_valid, r_hs})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      case ({ar_hs, r_hs})
        2'b10:   outst_q <= outst_q + CntW'(1);
        2'b01:   outst_q <= outst_q - CntW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  a_fifo_within_outst: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_cnt_q <= outst_q);
  a_outst_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outst_q <= CntW'(MAX_OUTST));

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Bench for axi_lite_mem_responder: vector table for single transactions, scoreboard queues
// for B/R responses, and directed sequences for back-pressure, reset and collision cases.
module tb_axi_lite_mem_responder;

  localparam logic [31:0] Base  = 32'h8000_0000;
  localparam logic [1:0]  Okay  = 2'b00;
  localparam logic [1:0]  SlvEr = 2'b10;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } rexp_t;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [1:0]  bq[$];
  rexp_t       rq[$];
  logic [63:0] model [8];
  vec_t        vecs [14];

  axi_lite_mem_responder_if bus ();

  axi_lite_mem_responder #(
    .BASE_ADDR   (Base),
    .DEPTH_WORDS (1024),
    .READ_LATENCY(2),
    .MAX_OUTST   (4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response scoreboard: compare whenever a handshake is about to complete
  always @(negedge clk) begin
    if (rst_n && bus.b_valid_o && bus.b_ready_i) begin
      if (bq.size() == 0) check("b_unexpected", 1, 0);
      else check("b_resp", {62'd0, bus.b_resp_o}, {62'd0, bq.pop_front()});
    end
    if (rst_n && bus.r_valid_o && bus.r_ready_i) begin
      if (rq.size() == 0) begin
        check("r_unexpected", 1, 0);
      end else begin
        rexp_t e;
        e = rq.pop_front();
        check("r_data", bus.r_data_o, e.data);
        check("r_resp", {62'd0, bus.r_resp_o}, {62'd0, e.resp});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic model_write(input logic [31:0] addr, input logic [63:0] data,
                             input logic [7:0] strb);
    int unsigned idx;
    idx = (addr - Base) >> 3;
    if (addr >= Base && idx < 8) begin
      for (int b = 0; b < 8; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input logic [1:0] exp_resp);
    int n;
    bus.aw_addr_i = addr;
    bus.w_data_i  = data;
    bus.w_strb_i  = strb;
    bus.aw_valid_i = 1'b1;
    bus.w_valid_i  = 1'b1;
    bq.push_back(exp_resp);
    if (exp_resp == Okay) model_write(addr, data, strb);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.aw_ready_o) break;
    end
    if (n == 50) check("aw_timeout", 0, 1);
    @(posedge clk); #1;
    bus.aw_valid_i = 1'b0;
    bus.w_valid_i  = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [63:0] exp_data,
                         input logic [1:0] exp_resp);
    int n;
    bus.ar_addr_i  = addr;
    bus.ar_valid_i = 1'b1;
    rq.push_back('{data: exp_data, resp: exp_resp});
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.ar_ready_o) break;
    end
    if (n == 50) check("ar_timeout", 0, 1);
    @(posedge clk); #1;
    bus.ar_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 100; i++) begin
      if (bq.size() == 0 && rq.size() == 0) break;
      @(posedge clk); #1;
    end
    if (i == 100) check("drain_timeout", bq.size() + rq.size(), 0);
  endtask

  initial begin
    int    accepted;
    logic  was_ready;
    int    k;

    vecs[0]  = '{1, 32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, Okay};
    vecs[1]  = '{1, 32'h8000_0008, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'h0, Okay};
    vecs[2]  = '{0, 32'h8000_0008, 64'h0, 8'h0, 64'h1122_3344_AAAA_AAAA, Okay};
    vecs[3]  = '{1, 32'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'h0, SlvEr};
    vecs[4]  = '{0, 32'h7FFF_FFF8, 64'h0, 8'h0, 64'h0, SlvEr};
    vecs[5]  = '{0, 32'h8000_2000, 64'h0, 8'h0, 64'h0, SlvEr};
    vecs[6]  = '{1, 32'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, Okay};
    vecs[7]  = '{0, 32'h8000_1FFF, 64'h0, 8'h0, 64'h0123_4567_89AB_CDEF, Okay};
    vecs[8]  = '{1, 32'h7FFF_FFF8, 64'h5555_5555_5555_5555, 8'hFF, 64'h0, SlvEr};
    vecs[9]  = '{0, 32'h8000_1FF8, 64'h0, 8'h0, 64'h0123_4567_89AB_CDEF, Okay};
    vecs[10] = '{0, 32'h8000_0000, 64'h0, 8'h0, 64'h0, Okay};
    vecs[11] = '{1, 32'h8000_001C, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81, 64'h0, Okay};
    vecs[12] = '{0, 32'h8000_0018, 64'h0, 8'h0, 64'hFF00_0000_0000_00FF, Okay};
    vecs[13] = '{1, 32'h0000_0000, 64'h1, 8'hFF, 64'h0, SlvEr};

    bus.aw_addr_i = '0; bus.aw_valid_i = 0; bus.w_data_i = '0; bus.w_strb_i = '0;
    bus.w_valid_i = 0;  bus.b_ready_i = 1;  bus.ar_addr_i = '0; bus.ar_valid_i = 0;
    bus.r_ready_i = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_b_valid", bus.b_valid_o, 0);
    check("rst_r_valid", bus.r_valid_o, 0);
    check("rst_b_resp", bus.b_resp_o, 0);
    check("rst_r_resp", bus.r_resp_o, 0);
    check("rst_r_data", bus.r_data_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ar_ready", bus.ar_ready_o, 1);
    check("post_rst_aw_ready", bus.aw_ready_o, 0);

    // Known contents for the words the bench reads
    for (int i = 0; i < 8; i++) do_write(Base + 32'(i * 8), 64'h0, 8'hFF, Okay);
    wait_drain();

    // Table of single transactions
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
      else do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
      wait_drain();
    end

    // Read latency: r_valid first appears two cycles after the AR handshake
    bus.ar_addr_i  = Base + 32'h8;
    bus.ar_valid_i = 1'b1;
    rq.push_back('{data: 64'h1122_3344_AAAA_AAAA, resp: Okay});
    @(negedge clk);
    check("lat_ar_ready", bus.ar_ready_o, 1);
    @(posedge clk); #1;
    bus.ar_valid_i = 1'b0;
    @(negedge clk);
    check("lat_cycle1_r_valid", bus.r_valid_o, 0);
    @(negedge clk);
    check("lat_cycle2_r_valid", bus.r_valid_o, 1);
    @(posedge clk); #1;
    wait_drain();

    // Outstanding limit under R back-pressure
    bus.r_ready_i  = 1'b0;
    accepted       = 0;
    k              = 0;
    bus.ar_addr_i  = Base;
    bus.ar_valid_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      was_ready = bus.ar_ready_o;
      if (was_ready) begin
        rq.push_back('{data: model[k], resp: Okay});
        accepted++;
      end
      @(posedge clk); #1;
      if (was_ready) begin
        k++;
        bus.ar_addr_i = Base + 32'(k * 8);
      end
    end
    bus.ar_valid_i = 1'b0;
    check("outst_accepted", accepted, 4);
    @(negedge clk);
    check("outst_ar_ready_low", bus.ar_ready_o, 0);
    check("stall_r_valid", bus.r_valid_o, 1);
    check("stall_r_data0", bus.r_data_o, rq[0].data);
    @(negedge clk);
    check("stall_r_data1", bus.r_data_o, rq[0].data);
    @(posedge clk); #1;
    bus.r_ready_i = 1'b1;
    wait_drain();
    check("outst_ar_ready_back", bus.ar_ready_o, 1);

    // B back-pressure blocks the next write
    bus.b_ready_i = 1'b0;
    do_write(Base + 32'h20, 64'h4444_0000_4444_0000, 8'hFF, Okay);
    bus.aw_addr_i  = Base + 32'h28;
    bus.w_data_i   = 64'h5555_1111_5555_1111;
    bus.w_strb_i   = 8'hFF;
    bus.aw_valid_i = 1'b1;
    bus.w_valid_i  = 1'b1;
    bq.push_back(Okay);
    model_write(Base + 32'h28, 64'h5555_1111_5555_1111, 8'hFF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_aw_ready", bus.aw_ready_o, 0);
      check("bp_b_valid", bus.b_valid_o, 1);
      @(posedge clk); #1;
    end
    bus.b_ready_i = 1'b1;
    begin
      int n;
      for (n = 0; n < 20; n++) begin
        @(negedge clk);
        if (bus.aw_ready_o) break;
      end
      if (n == 20) check("bp_aw_timeout", 0, 1);
    end
    @(posedge clk); #1;
    bus.aw_valid_i = 1'b0;
    bus.w_valid_i  = 1'b0;
    wait_drain();
    do_read(Base + 32'h20, model[4], Okay);
    do_read(Base + 32'h28, model[5], Okay);
    wait_drain();

    // Reset with reads in flight discards them, memory survives
    bus.r_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) do_read(Base + 32'(i * 8), model[i], Okay);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rq.delete();
    bus.r_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_flush_r_valid", bus.r_valid_o, 0);
      check("rst_flush_ar_ready", bus.ar_ready_o, 1);
      @(posedge clk); #1;
    end
    do_read(Base + 32'h8, model[1], Okay);
    wait_drain();

    // Same-cycle write and read to one word returns the old value
    bus.aw_addr_i  = Base + 32'h10;
    bus.w_data_i   = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.w_strb_i   = 8'hFF;
    bus.ar_addr_i  = Base + 32'h10;
    bus.aw_valid_i = 1'b1;
    bus.w_valid_i  = 1'b1;
    bus.ar_valid_i = 1'b1;
    bq.push_back(Okay);
    rq.push_back('{data: model[2], resp: Okay});
    @(negedge clk);
    check("coll_aw_ready", bus.aw_ready_o, 1);
    check("coll_ar_ready", bus.ar_ready_o, 1);
    @(posedge clk); #1;
    bus.aw_valid_i = 1'b0;
    bus.w_valid_i  = 1'b0;
    bus.ar_valid_i = 1'b0;
    model_write(Base + 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wait_drain();
    do_read(Base + 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, Okay);
    wait_drain();

    // One read per cycle with R always ready
    bus.ar_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.ar_addr_i = Base + 32'(i * 8);
      @(negedge clk);
      check("tput_ar_ready", bus.ar_ready_o, 1);
      rq.push_back('{data: model[i], resp: Okay});
      @(posedge clk); #1;
    end
    bus.ar_valid_i = 1'b0;
    wait_drain();

    check("end_bq_empty", bq.size(), 0);
    check("end_rq_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
